// File: rtl/dispatch_ctrl.sv
// Instruction dispatch controller: a small FIFO between fetch and the decoder that
// issues one decoded instruction per cycle to either the reservation station or the LSB.
module dispatch_ctrl #(
    parameter int QDEPTH       = 4,
    parameter int OPENUM_W     = 6,
    parameter int OPENUM_NOP   = 0,
    parameter int OPENUM_LS_LO = 11,
    parameter int OPENUM_LS_HI = 18
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rdy,
    input  logic                flush,
    input  logic                if_valid,
    input  logic [31:0]         if_inst,
    input  logic [31:0]         if_pc,
    output logic                if_ready,
    output logic                dec_ena,
    output logic [31:0]         dec_inst,
    input  logic [OPENUM_W-1:0] dec_openum,
    input  logic [4:0]          dec_rd,
    input  logic [4:0]          dec_rs1,
    input  logic [4:0]          dec_rs2,
    input  logic [31:0]         dec_imm,
    input  logic                rob_full,
    input  logic                rs_full,
    input  logic                lsb_full,
    output logic                disp_valid,
    output logic                disp_to_lsb,
    output logic [OPENUM_W-1:0] disp_openum,
    output logic [4:0]          disp_rd,
    output logic [4:0]          disp_rs1,
    output logic [4:0]          disp_rs2,
    output logic [31:0]         disp_imm,
    output logic [31:0]         disp_pc,
    output logic                stall
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam logic [PTR_W:0]      FULL_CNT = (PTR_W + 1)'(QDEPTH);
    localparam logic [OPENUM_W-1:0] NOP_CODE = OPENUM_W'(OPENUM_NOP);
    localparam logic [OPENUM_W-1:0] LS_LO    = OPENUM_W'(OPENUM_LS_LO);
    localparam logic [OPENUM_W-1:0] LS_HI    = OPENUM_W'(OPENUM_LS_HI);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    logic [31:0]      q_inst [QDEPTH];
    logic [31:0]      q_pc   [QDEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic [0:0]       state_reg;
    logic [0:0]       state_next;

    logic head_valid;
    logic head_nop;
    logic head_ls;
    logic head_blocked;
    logic active;
    logic do_push;
    logic do_disp;
    logic do_drop;
    logic do_pop;

    assign if_ready = (count_reg < FULL_CNT);
    assign dec_ena  = head_valid;
    assign dec_inst = q_inst[head_reg];
    assign stall    = (state_reg == ST_STALL);

    // Head classification comes straight from the external decoder looking at dec_inst.
    assign head_valid   = (count_reg != '0);
    assign head_nop     = (dec_openum == NOP_CODE);
    assign head_ls      = (dec_openum >= LS_LO) && (dec_openum <= LS_HI);
    assign head_blocked = rob_full | (head_ls ? lsb_full : rs_full);

    assign active  = rdy & ~flush;
    assign do_push = active & if_valid & if_ready;
    assign do_disp = active & head_valid & ~head_nop & ~head_blocked;
    assign do_drop = active & head_valid & head_nop;
    assign do_pop  = do_disp | do_drop;

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        if (do_disp) begin
            state_next = ST_RUN;
        end else if (active && head_valid && !head_nop && head_blocked) begin
            state_next = ST_STALL;
        end
    end

    // Queue storage carries no reset; validity is tracked by count/head/tail alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            q_inst[tail_reg] <= if_inst;
            q_pc[tail_reg]   <= if_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
            state_reg   <= ST_RUN;
            disp_valid  <= 1'b0;
            disp_to_lsb <= 1'b0;
            disp_openum <= NOP_CODE;
            disp_rd     <= '0;
            disp_rs1    <= '0;
            disp_rs2    <= '0;
            disp_imm    <= '0;
            disp_pc     <= '0;
        end else if (rdy) begin
            if (flush) begin
                head_reg   <= '0;
                tail_reg   <= '0;
                count_reg  <= '0;
                state_reg  <= ST_RUN;
                disp_valid <= 1'b0;
            end else begin
                if (do_pop) begin
                    head_reg <= head_reg + 1'b1;
                end
                if (do_push) begin
                    tail_reg <= tail_reg + 1'b1;
                end
                count_reg  <= count_next;
                state_reg  <= state_next;
                disp_valid <= do_disp;
                if (do_disp) begin
                    disp_to_lsb <= head_ls;
                    disp_openum <= dec_openum;
                    disp_rd     <= dec_rd;
                    disp_rs1    <= dec_rs1;
                    disp_rs2    <= dec_rs2;
                    disp_imm    <= dec_imm;
                    disp_pc     <= q_pc[head_reg];
                end
            end
        end
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl; a tiny field-slicing decoder model stands in for the
// real decoder so openum, registers and immediate are known for every queued word.
module tb_dispatch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, rdy, flush, if_valid, if_ready, dec_ena;
    logic [31:0] if_inst, if_pc, dec_inst, dec_imm, disp_imm, disp_pc;
    logic [5:0]  dec_openum, disp_openum;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2, disp_rd, disp_rs1, disp_rs2;
    logic        rob_full, rs_full, lsb_full;
    logic        disp_valid, disp_to_lsb, stall;

    int total = 0;
    int bad   = 0;

    logic [5:0] s2_ops [5] = '{6'd10, 6'd11, 6'd18, 6'd19, 6'd1};
    logic       s2_lsb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    always #5 clk = ~clk;

    dispatch_ctrl #(
        .QDEPTH(4), .OPENUM_W(6), .OPENUM_NOP(0), .OPENUM_LS_LO(11), .OPENUM_LS_HI(18)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_ready(if_ready),
        .dec_ena(dec_ena), .dec_inst(dec_inst), .dec_openum(dec_openum),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_imm(dec_imm),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .disp_valid(disp_valid), .disp_to_lsb(disp_to_lsb), .disp_openum(disp_openum),
        .disp_rd(disp_rd), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
        .disp_imm(disp_imm), .disp_pc(disp_pc), .stall(stall)
    );

    // Word layout: [31:16] imm, [15:11] rs1, [10:6] rd, [5:0] openum; rs2 reuses [20:16].
    always_comb begin
        dec_openum = dec_inst[5:0];
        dec_rd     = dec_inst[10:6];
        dec_rs1    = dec_inst[15:11];
        dec_rs2    = dec_inst[20:16];
        dec_imm    = {16'h0000, dec_inst[31:16]};
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [15:0] imm);
        logic [4:0] rs1;
        rs1 = rd + 5'd1;
        return {imm, rs1, rd, op};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rdy && disp_valid)
            $display("dispatch pc=%h openum=%0d to_lsb=%0b rd=%0d imm=%h",
                     disp_pc, disp_openum, disp_to_lsb, disp_rd, disp_imm);
    end

    initial begin
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
        if_valid = 1'b0; if_inst = '0; if_pc = '0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(disp_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ready", 32'(if_ready), 32'd1);
        chk("rst_dec_ena", 32'(dec_ena), 32'd0);
        chk("rst_openum", 32'(disp_openum), 32'd0);
        chk("rst_lsb", 32'(disp_to_lsb), 32'd0);
        chk("rst_pc", disp_pc, 32'd0);
        chk("rst_imm", disp_imm, 32'd0);
        rst_n = 1'b1;

        // single addi, one-cycle latency
        if_valid = 1'b1; if_inst = mk(6'd1, 5'd3, 16'h0011); if_pc = 32'h0;
        @(negedge clk);
        if_valid = 1'b0;
        chk("s1_dec_ena", 32'(dec_ena), 32'd1);
        chk("s1_dec_inst", dec_inst, mk(6'd1, 5'd3, 16'h0011));
        chk("s1_early", 32'(disp_valid), 32'd0);
        @(negedge clk);
        chk("s1_valid", 32'(disp_valid), 32'd1);
        chk("s1_lsb", 32'(disp_to_lsb), 32'd0);
        chk("s1_pc", disp_pc, 32'h0);
        chk("s1_openum", 32'(disp_openum), 32'd1);
        chk("s1_rd", 32'(disp_rd), 32'd3);
        chk("s1_rs1", 32'(disp_rs1), 32'd4);
        chk("s1_rs2", 32'(disp_rs2), 32'd17);
        chk("s1_imm", disp_imm, 32'h11);
        @(negedge clk);
        chk("s1_pulse", 32'(disp_valid), 32'd0);
        chk("s1_empty", 32'(dec_ena), 32'd0);

        // fill to full with everything blocked, then drain in order
        rob_full = 1'b1; rs_full = 1'b1; lsb_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("s2_ready", 32'(if_ready), (k < 4) ? 32'd1 : 32'd0);
            if_valid = 1'b1;
            if_inst  = mk(s2_ops[k], 5'(k), 16'(16'h0200 + k));
            if_pc    = 32'h100 + 32'(4 * k);
            @(negedge clk);
            chk("s2_blocked", 32'(disp_valid), 32'd0);
        end
        chk("s2_full", 32'(if_ready), 32'd0);
        chk("s2_stall", 32'(stall), 32'd1);
        if_valid = 1'b0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("s2_valid", 32'(disp_valid), 32'd1);
            chk("s2_pc", disp_pc, 32'h100 + 32'(4 * k));
            chk("s2_openum", 32'(disp_openum), 32'(s2_ops[k]));
            chk("s2_lsb", 32'(disp_to_lsb), 32'(s2_lsb[k]));
            chk("s2_imm", disp_imm, 32'h200 + 32'(k));
        end
        @(negedge clk);
        chk("s2_done", 32'(disp_valid), 32'd0);
        chk("s2_unstall", 32'(stall), 32'd0);
        chk("s2_ready_end", 32'(if_ready), 32'd1);

        // lw blocked only by lsb_full
        lsb_full = 1'b1;
        if_valid = 1'b1; if_inst = mk(6'd13, 5'd7, 16'h0300); if_pc = 32'h200;
        @(negedge clk);
        if_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("s3_stall", 32'(stall), 32'd1);
            chk("s3_hold", 32'(disp_valid), 32'd0);
        end
        lsb_full = 1'b0;
        @(negedge clk);
        chk("s3_valid", 32'(disp_valid), 32'd1);
        chk("s3_lsb", 32'(disp_to_lsb), 32'd1);
        chk("s3_pc", disp_pc, 32'h200);
        chk("s3_openum", 32'(disp_openum), 32'd13);
        chk("s3_unstall", 32'(stall), 32'd0);

        // undecodable head dropped despite rob_full, with a push on the same edge
        rob_full = 1'b1;
        if_valid = 1'b1; if_inst = mk(6'd0, 5'd1, 16'hdead); if_pc = 32'h300;
        @(negedge clk);
        if_inst = mk(6'd2, 5'd9, 16'h0400); if_pc = 32'h304;
        @(negedge clk);
        if_valid = 1'b0;
        chk("s4_nopulse", 32'(disp_valid), 32'd0);
        chk("s4_nostall", 32'(stall), 32'd0);
        chk("s4_next", dec_inst, mk(6'd2, 5'd9, 16'h0400));
        chk("s4_count1", 32'(dec_ena), 32'd1);
        rob_full = 1'b0;
        @(negedge clk);
        chk("s4_valid", 32'(disp_valid), 32'd1);
        chk("s4_pc", disp_pc, 32'h304);
        @(negedge clk);
        chk("s4_empty", 32'(dec_ena), 32'd0);

        // flush a 3-deep queue while fetch still offers a word
        rob_full = 1'b1; rs_full = 1'b1; lsb_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if_valid = 1'b1;
            if_inst  = mk(6'd3, 5'(k), 16'h0500);
            if_pc    = 32'h400 + 32'(4 * k);
            @(negedge clk);
        end
        chk("s5_queued", 32'(dec_ena), 32'd1);
        chk("s5_stall", 32'(stall), 32'd1);
        flush = 1'b1; if_inst = mk(6'd4, 5'd2, 16'h0501); if_pc = 32'h500;
        @(negedge clk);
        flush = 1'b0; if_valid = 1'b0;
        chk("s5_empty", 32'(dec_ena), 32'd0);
        chk("s5_ready", 32'(if_ready), 32'd1);
        chk("s5_run", 32'(stall), 32'd0);
        chk("s5_nopulse", 32'(disp_valid), 32'd0);
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("s5_gone", 32'(disp_valid), 32'd0);
        end

        // rdy low for three cycles freezes everything, flush included
        if_valid = 1'b1; if_inst = mk(6'd5, 5'd10, 16'h0600); if_pc = 32'h600;
        @(negedge clk);
        if_inst = mk(6'd5, 5'd11, 16'h0601); if_pc = 32'h604;
        @(negedge clk);
        chk("s6_first", disp_pc, 32'h600);
        chk("s6_valid0", 32'(disp_valid), 32'd1);
        rdy = 1'b0; flush = 1'b1;
        if_inst = mk(6'd12, 5'd12, 16'h0602); if_pc = 32'h608;
        repeat (3) begin
            @(negedge clk);
            chk("s6_frz_valid", 32'(disp_valid), 32'd1);
            chk("s6_frz_pc", disp_pc, 32'h600);
            chk("s6_frz_head", dec_inst, mk(6'd5, 5'd11, 16'h0601));
            chk("s6_frz_ena", 32'(dec_ena), 32'd1);
        end
        rdy = 1'b1; flush = 1'b0;
        @(negedge clk);
        if_valid = 1'b0;
        chk("s6_second", disp_pc, 32'h604);
        chk("s6_valid1", 32'(disp_valid), 32'd1);
        @(negedge clk);
        chk("s6_third", disp_pc, 32'h608);
        chk("s6_third_lsb", 32'(disp_to_lsb), 32'd1);
        @(negedge clk);
        chk("s6_idle", 32'(disp_valid), 32'd0);
        chk("s6_empty", 32'(dec_ena), 32'd0);

        // asynchronous reset mid-operation discards the queue
        rob_full = 1'b1; rs_full = 1'b1; lsb_full = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if_valid = 1'b1;
            if_inst  = mk(6'd6, 5'(k), 16'h0700);
            if_pc    = 32'h700 + 32'(4 * k);
            @(negedge clk);
        end
        if_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("s7_async_ena", 32'(dec_ena), 32'd0);
        chk("s7_async_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("s7_nopulse", 32'(disp_valid), 32'd0);
            chk("s7_empty", 32'(dec_ena), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
